// File: rtl/assoc_data_memory_system.sv
// Set-associative, write-through data cache in front of a word-addressed
// main memory. Round-robin replacement per set, optional write-allocate.

// Main memory: word write port plus a line-wide combinational read port.
// Miss latency is modelled by the cache controller's cycle counter.
module assoc_data_memory_system_mem #(
    parameter int DW = 32,
    parameter int AW = 10,
    parameter int BW = 4
) (
    input  logic                   CLK,
    input  logic                   i_we,
    input  logic [AW-1:0]          i_waddr,
    input  logic [DW-1:0]          i_wdata,
    input  logic [AW-1:0]          i_line_base,
    output logic [BW-1:0][DW-1:0]  o_line
);
    logic [DW-1:0] D_MEM [0:2**AW-1];

    // Word write, no reset: memory contents survive rst
    always_ff @(posedge CLK) begin
        if (i_we) D_MEM[i_waddr] <= i_wdata;
    end

    // Whole line starting at the block-aligned base
    always_comb begin
        for (int b = 0; b < BW; b++) o_line[b] = D_MEM[i_line_base + AW'(b)];
    end
endmodule

module assoc_data_memory_system #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int WAYS        = 2,
    parameter int SETS        = 8,
    parameter int BLOCK_WORDS = 4,
    parameter int MEM_LATENCY = 2,
    parameter int WRITE_ALLOC = 0
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [ADDR_WIDTH-1:0] WordAddress,
    input  logic [DATA_WIDTH-1:0] DataIn,
    output logic                  Stall,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic [31:0]           HitCount,
    output logic [31:0]           MissCount
);
    localparam int AW       = ADDR_WIDTH;
    localparam int OW       = $clog2(BLOCK_WORDS);
    localparam int SW       = (SETS > 1) ? $clog2(SETS) : 1;
    localparam int BW       = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam int WW       = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int FILL_CYC = BLOCK_WORDS * MEM_LATENCY;
    localparam int CW       = $clog2(FILL_CYC + MEM_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t r_state, w_next;
    logic   r_valid [WAYS][SETS];
    logic [AW-1:0] r_tag [WAYS][SETS];
    logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0] r_data [WAYS][SETS];
    logic [WW-1:0] r_ptr [SETS];
    logic [CW-1:0] r_cnt;
    logic          r_miss;
    logic [DATA_WIDTH-1:0] r_dout;

    logic [BW-1:0] w_off;
    logic [SW-1:0] w_set;
    logic [AW-1:0] w_tag, w_base;
    logic          w_rd, w_wr, w_hit, w_any_inv;
    logic [WW-1:0] w_hit_way, w_vict;
    logic [DATA_WIDTH-1:0] w_hit_word;
    logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0] w_line;
    logic w_fill_op, w_wr_op, w_fill_end, w_wr_end, w_miss_start, w_rd_done, w_done;

    assign w_off  = BW'(WordAddress & AW'(BLOCK_WORDS - 1));
    assign w_set  = SW'((WordAddress >> OW) & AW'(SETS - 1));
    assign w_tag  = WordAddress >> (OW + $clog2(SETS));
    assign w_base = WordAddress & ~AW'(BLOCK_WORDS - 1);

    assoc_data_memory_system_mem #(.DW(DATA_WIDTH), .AW(AW), .BW(BLOCK_WORDS)) Main_MEM (
        .CLK(CLK), .i_we(w_wr_end && !rst), .i_waddr(WordAddress), .i_wdata(DataIn),
        .i_line_base(w_base), .o_line(w_line)
    );

    // Tag lookup and victim choice: lowest invalid way, else the set pointer
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_any_inv = 1'b0;
        w_vict    = r_ptr[w_set];
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w][w_set] && r_tag[w][w_set] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = WW'(w);
            end
            if (!w_any_inv && !r_valid[w][w_set]) begin
                w_any_inv = 1'b1;
                w_vict    = WW'(w);
            end
        end
        w_hit_word = r_data[w_hit_way][w_set][w_off];
    end

    // FSM next state and outputs; the IDLE request cycle is the first busy cycle
    always_comb begin
        w_fill_op    = 1'b0;
        w_wr_op      = 1'b0;
        w_miss_start = 1'b0;
        w_rd         = MemRead & ~MemWrite;
        w_wr         = MemWrite;
        case (r_state)
            IDLE: begin
                if (w_wr) begin
                    if (!w_hit && WRITE_ALLOC != 0) w_fill_op = 1'b1;
                    else                            w_wr_op   = 1'b1;
                    w_miss_start = !w_hit;
                end else if (w_rd && !w_hit) begin
                    w_fill_op    = 1'b1;
                    w_miss_start = 1'b1;
                end
            end
            FILL:    w_fill_op = 1'b1;
            WRITE:   w_wr_op   = 1'b1;
            default: ;
        endcase
        w_fill_end = w_fill_op && (r_cnt == CW'(FILL_CYC - 1));
        w_wr_end   = w_wr_op && (r_cnt == CW'(MEM_LATENCY - 1));
        if (w_fill_end)    w_next = IDLE;
        else if (w_fill_op) w_next = FILL;
        else if (w_wr_end)  w_next = DONE;
        else if (w_wr_op)   w_next = WRITE;
        else                w_next = IDLE;
        w_rd_done = (r_state == IDLE) && w_rd && w_hit;
        w_done    = w_rd_done || (r_state == DONE);
        Stall     = !rst && (w_fill_op || w_wr_op);
        DataOut   = rst ? '0 : (w_rd_done ? w_hit_word : r_dout);
    end

    // Control state, valid bits, victim pointers, counters
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_miss    <= 1'b0;
            r_dout    <= '0;
            HitCount  <= '0;
            MissCount <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_ptr[s] <= '0;
                for (int w = 0; w < WAYS; w++) r_valid[w][s] <= 1'b0;
            end
        end else begin
            r_state <= w_next;
            if (w_fill_end || w_wr_end)  r_cnt <= '0;
            else if (w_fill_op || w_wr_op) r_cnt <= r_cnt + 1'b1;
            else                          r_cnt <= '0;
            if (w_fill_end) begin
                r_valid[w_vict][w_set] <= 1'b1;
                if (!w_any_inv)
                    r_ptr[w_set] <= (r_ptr[w_set] == WW'(WAYS - 1)) ? '0 : r_ptr[w_set] + 1'b1;
            end
            if (w_rd_done) r_dout <= w_hit_word;
            if (w_done) begin
                r_miss <= 1'b0;
                if (r_miss) MissCount <= MissCount + 32'd1;
                else        HitCount  <= HitCount + 32'd1;
            end else if (r_state == IDLE && w_miss_start) begin
                r_miss <= 1'b1;
            end
        end
    end

    // Line data and tags: no reset needed, guarded by valid bits
    always_ff @(posedge CLK) begin
        if (!rst) begin
            if (w_fill_end) begin
                r_tag[w_vict][w_set]  <= w_tag;
                r_data[w_vict][w_set] <= w_line;
            end
            if (w_wr_end && w_hit) r_data[w_hit_way][w_set][w_off] <= DataIn;
        end
    end
endmodule

// File: tb/tb_assoc_data_memory_system.sv
// Randomised and directed bench with a FIFO-per-set cache reference model.
module tb_assoc_data_memory_system;
    localparam int AW = 10, WAYS = 2, SETS = 8, B = 4, L = 2;

    logic        CLK = 1'b0, rst = 1'b1, MemRead = 1'b0, MemWrite = 1'b0;
    logic [AW-1:0] WordAddress = '0;
    logic [31:0] DataIn = '0, DataOut, HitCount, MissCount;
    logic        Stall;

    assoc_data_memory_system dut (
        .CLK(CLK), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .WordAddress(WordAddress), .DataIn(DataIn), .Stall(Stall),
        .DataOut(DataOut), .HitCount(HitCount), .MissCount(MissCount)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0, n_fail = 0;
    // Replacement is invalid-first then round-robin with no invalidation, i.e. FIFO per set
    int unsigned q_set [SETS][$];
    logic [31:0] m_mem [1024];
    logic [31:0] m_last;
    int unsigned m_hit, m_miss;

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) q_set[s].delete();
        m_hit = 0; m_miss = 0; m_last = 0;
    endtask

    task automatic model(input logic rd, input logic wr, input int unsigned a, input logic [31:0] d,
                         output int es, output logic [31:0] ed);
        int unsigned s, t;
        logic hit;
        s = (a / B) % SETS;
        t = a / (B * SETS);
        hit = 1'b0;
        foreach (q_set[s][i]) if (q_set[s][i] == t) hit = 1'b1;
        if (wr) begin
            es = L;
            ed = m_last;
            m_mem[a] = d;
        end else begin
            es = hit ? 0 : B * L;
            if (!hit) begin
                if (q_set[s].size() == WAYS) void'(q_set[s].pop_front());
                q_set[s].push_back(t);
            end
            ed = m_mem[a];
            m_last = ed;
        end
        if (rd || wr) begin
            if (hit) m_hit++;
            else     m_miss++;
        end
    endtask

    task automatic access(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                          output int st, output logic [31:0] dout);
        MemRead = rd; MemWrite = wr; WordAddress = a; DataIn = d; st = 0;
        #1;
        while (Stall && st < 100) begin
            st++;
            @(posedge CLK); #1;
        end
        dout = DataOut;
        @(posedge CLK); #1;
        MemRead = 0; MemWrite = 0;
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        rst = 1; MemRead = 0; MemWrite = 0;
        @(posedge CLK); #1;
        rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1; MemRead = 1; WordAddress = 10'h000;
        @(posedge CLK); #1;
        n_tests++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", Stall); end
        n_tests++; if (DataOut !== 32'h0) begin n_fail++; $display("FAIL reset_dout: got %0h expected 0", DataOut); end
        n_tests++; if (HitCount !== 32'h0) begin n_fail++; $display("FAIL reset_hit: got %0d expected 0", HitCount); end
        n_tests++; if (MissCount !== 32'h0) begin n_fail++; $display("FAIL reset_miss: got %0d expected 0", MissCount); end
        MemRead = 0; rst = 0;
        model_reset();
    endtask

    task automatic test_fill();
        int st, es; logic [31:0] d, ed;
        for (int a = 0; a < 4; a++) begin
            model(1, 0, a, 0, es, ed);
            access(1, 0, AW'(a), 0, st, d);
            n_tests++; if (st !== ((a == 0) ? 8 : 0)) begin n_fail++; $display("FAIL fill_stall[%0d]: got %0d expected %0d", a, st, (a == 0) ? 8 : 0); end
            n_tests++; if (d !== 32'(3 * a + 1)) begin n_fail++; $display("FAIL fill_dout[%0d]: got %0h expected %0h", a, d, 3 * a + 1); end
        end
        n_tests++; if (HitCount !== 32'd3 || MissCount !== 32'd1) begin n_fail++; $display("FAIL fill_counts: got %0d/%0d expected 3/1", HitCount, MissCount); end
    endtask

    task automatic test_replace();
        logic [AW-1:0] seq [6];
        logic          exp_hit [6];
        int st, es; logic [31:0] d, ed;
        seq = '{10'h000, 10'h020, 10'h000, 10'h040, 10'h020, 10'h000};
        exp_hit = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            model(1, 0, seq[i], 0, es, ed);
            access(1, 0, seq[i], 0, st, d);
            n_tests++; if (st !== (exp_hit[i] ? 0 : 8) || d !== ed) begin n_fail++; $display("FAIL replace[%0d]: got stall %0d data %0h expected stall %0d data %0h", i, st, d, exp_hit[i] ? 0 : 8, ed); end
        end
        n_tests++; if (HitCount !== 32'd2 || MissCount !== 32'd4) begin n_fail++; $display("FAIL replace_counts: got %0d/%0d expected 2/4", HitCount, MissCount); end
    endtask

    task automatic test_write_hit();
        int st, es; logic [31:0] d, ed;
        do_reset();
        model(1, 0, 0, 0, es, ed); access(1, 0, 10'h000, 0, st, d);
        model(0, 1, 1, 32'hDEADBEEF, es, ed); access(0, 1, 10'h001, 32'hDEADBEEF, st, d);
        n_tests++; if (st !== 2) begin n_fail++; $display("FAIL wr_hit_stall: got %0d expected 2", st); end
        n_tests++; if (dut.Main_MEM.D_MEM[1] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_hit_mem: got %0h expected deadbeef", dut.Main_MEM.D_MEM[1]); end
        n_tests++; if (HitCount !== 32'd1) begin n_fail++; $display("FAIL wr_hit_count: got %0d expected 1", HitCount); end
        model(1, 0, 1, 0, es, ed); access(1, 0, 10'h001, 0, st, d);
        n_tests++; if (st !== 0 || d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_hit_read: got stall %0d data %0h expected 0 deadbeef", st, d); end
    endtask

    task automatic test_write_around();
        int st, es; logic [31:0] d, ed; int unsigned mc;
        mc = MissCount;
        model(0, 1, 10'h100, 32'h12345678, es, ed); access(0, 1, 10'h100, 32'h12345678, st, d);
        n_tests++; if (st !== 2 || dut.Main_MEM.D_MEM[10'h100] !== 32'h12345678) begin n_fail++; $display("FAIL wr_around: got stall %0d mem %0h expected 2 12345678", st, dut.Main_MEM.D_MEM[10'h100]); end
        n_tests++; if (MissCount !== mc + 1) begin n_fail++; $display("FAIL wr_around_count: got %0d expected %0d", MissCount, mc + 1); end
        model(1, 0, 10'h100, 0, es, ed); access(1, 0, 10'h100, 0, st, d);
        n_tests++; if (st !== 8 || d !== 32'h12345678) begin n_fail++; $display("FAIL wr_around_read: got stall %0d data %0h expected 8 12345678", st, d); end
    endtask

    task automatic test_rw_both();
        int st, es; logic [31:0] d, ed;
        model(1, 1, 2, 32'h55, es, ed); access(1, 1, 10'h002, 32'h55, st, d);
        n_tests++; if (st !== 2 || d !== 32'h12345678) begin n_fail++; $display("FAIL rw_both: got stall %0d data %0h expected 2 12345678", st, d); end
        n_tests++; if (dut.Main_MEM.D_MEM[2] !== 32'h55) begin n_fail++; $display("FAIL rw_both_mem: got %0h expected 55", dut.Main_MEM.D_MEM[2]); end
        model(1, 0, 2, 0, es, ed); access(1, 0, 10'h002, 0, st, d);
        n_tests++; if (st !== 0 || d !== 32'h55) begin n_fail++; $display("FAIL rw_both_read: got stall %0d data %0h expected 0 55", st, d); end
    endtask

    task automatic test_rst_mid_fill();
        int st, es; logic [31:0] d, ed;
        MemRead = 1; WordAddress = 10'h084;
        repeat (3) @(posedge CLK);
        #1 rst = 1;
        #1;
        n_tests++; if (Stall !== 1'b0 || HitCount !== 0 || MissCount !== 0) begin n_fail++; $display("FAIL mid_fill_rst: got stall %b counts %0d/%0d expected 0 0/0", Stall, HitCount, MissCount); end
        @(posedge CLK); #1;
        rst = 0; MemRead = 0;
        model_reset();
        model(1, 0, 10'h084, 0, es, ed); access(1, 0, 10'h084, 0, st, d);
        n_tests++; if (st !== 8 || d !== ed) begin n_fail++; $display("FAIL mid_fill_retry: got stall %0d data %0h expected 8 %0h", st, d, ed); end
    endtask

    task automatic test_random();
        int st, es, bad; logic [31:0] d, ed, wd; logic rd, wr; logic [AW-1:0] a; int unsigned op;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 7);
            rd = (op < 5) || (op == 7);
            wr = (op >= 5);
            a  = AW'(($urandom_range(0, 4) << 5) | ($urandom_range(0, 1) << 2) | $urandom_range(0, 3));
            wd = $urandom;
            model(rd, wr, a, wd, es, ed);
            access(rd, wr, a, wd, st, d);
            n_tests++; if (st !== es || d !== ed) begin n_fail++; $display("FAIL random[%0d] addr %0h wr %b: got stall %0d data %0h expected %0d %0h", i, a, wr, st, d, es, ed); end
        end
        n_tests++; if (HitCount !== m_hit || MissCount !== m_miss) begin n_fail++; $display("FAIL random_counts: got %0d/%0d expected %0d/%0d", HitCount, MissCount, m_hit, m_miss); end
        bad = 0;
        for (int i = 0; i < 1024; i++) if (dut.Main_MEM.D_MEM[i] !== m_mem[i]) bad++;
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL random_mem: got %0d differing words expected 0", bad); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            dut.Main_MEM.D_MEM[i] = 32'(3 * i + 1);
            m_mem[i] = 32'(3 * i + 1);
        end
        test_reset();
        test_fill();
        test_replace();
        test_write_hit();
        test_write_around();
        test_rw_both();
        test_rst_mid_fill();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/assoc_data_memory_system.md
ASSOC_DATA_MEMORY_SYSTEM -- requirements
Module: assoc_data_memory_system

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, word address width; main memory depth is 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter WAYS, default 2, associativity; legal values 1, 2, 4.
REQ-004 SHALL have parameter SETS, default 8, number of sets; power of two.
REQ-005 SHALL have parameter BLOCK_WORDS, default 4, words per line; power of two, at least 1.
REQ-006 SHALL have parameter MEM_LATENCY, default 2, main memory cycles per word access; at least 1.
REQ-007 SHALL have parameter WRITE_ALLOC, default 0; 0 = write-around on miss, 1 = fill line then write on miss.
REQ-008 SHALL have port CLK  input  1  clock; all state changes on the rising edge.
REQ-009 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-010 SHALL have ports MemRead  input  1  read request, and MemWrite  input  1  write request.
REQ-011 SHALL have port WordAddress  input  ADDR_WIDTH  word address.
REQ-012 SHALL have port DataIn  input  DATA_WIDTH  write data.
REQ-013 SHALL have port Stall  output  1  access not yet complete; requester holds all inputs stable while high.
REQ-014 SHALL have port DataOut  output  DATA_WIDTH  read data, valid in a completing read cycle.
REQ-015 SHALL have ports HitCount and MissCount, each output 32, counts of completed accesses.
REQ-016 SHALL contain main memory instance Main_MEM with array D_MEM[0:2**ADDR_WIDTH-1], which a bench can load hierarchically.

Function
REQ-017 SHALL split WordAddress into offset (low log2 BLOCK_WORDS bits), index (next log2 SETS bits) and tag (remaining bits).
REQ-018 SHALL store per line a valid bit, a tag and BLOCK_WORDS data words; per set, a round-robin victim pointer of log2 WAYS bits.
REQ-019 SHALL implement FSM states IDLE, FILL, WRITE, DONE.
REQ-020 SHALL perform lookup combinationally in IDLE: a read hit drives DataOut with the addressed word, holds Stall=0, and completes in that cycle.
REQ-021 SHALL, on a read miss in IDLE, assert Stall and enter FILL, then fetch BLOCK_WORDS words at MEM_LATENCY cycles each, so Stall stays high for BLOCK_WORDS*MEM_LATENCY cycles.
REQ-022 SHALL, at the end of FILL, install the line (valid=1, tag written) and return to IDLE; the held read then hits and completes.
REQ-023 SHALL choose the victim as the lowest-numbered invalid way; if no way is invalid, it SHALL use the set pointer and then advance the pointer modulo WAYS.
REQ-024 SHALL handle every write as write-through: Stall stays high in WRITE for MEM_LATENCY cycles, then D_MEM is updated.
REQ-025 SHALL, on a write hit, also update the cached word in the same cycle as the D_MEM update.
REQ-026 SHALL, on a write miss: with WRITE_ALLOC=0, leave the cache unchanged; with WRITE_ALLOC=1, run FILL first and then the write-hit sequence.
REQ-027 SHALL enter DONE for one cycle after WRITE, with Stall=0; the write completes in DONE; if the request is still held in the next IDLE cycle, it is a new access.
REQ-028 SHALL give MemWrite priority when MemRead and MemWrite are both high; the read is ignored.
REQ-029 SHALL keep DataOut at its previous value in cycles that are not completing reads.
REQ-030 SHALL count each completing cycle once: MissCount if the access entered FILL or was a write-around miss, else HitCount.
REQ-031 SHALL let both counters wrap from 2**32-1 to 0.

Reset
REQ-032 SHALL, while rst is high, force: state IDLE, all valid bits 0, all victim pointers 0, Stall=0, DataOut=0, HitCount=0, MissCount=0.
REQ-033 SHALL, when reset is asserted mid-FILL or mid-WRITE, abort the operation immediately; D_MEM is not reset, and an aborted write leaves D_MEM unchanged.

Verification (defaults; D_MEM[i]=3*i+1 preloaded)
REQ-034 Read 0x000 -> Stall high 8 cycles, then DataOut=0x1, MissCount=1; reads 0x001..0x003 -> each completes with no stall, DataOut=0x4, 0x7, 0xA, HitCount=3.
REQ-035 Reads 0x000, 0x020, 0x000, 0x040, 0x020, 0x000 (all set 0) -> miss, miss, hit, miss (evicts way0), hit, miss.
REQ-036 Write 0x001=0xDEADBEEF after 0x000 is cached -> Stall 2 cycles, D_MEM[1]=0xDEADBEEF, HitCount+1; a following read of 0x001 hits and returns 0xDEADBEEF.
REQ-037 Write 0x100=0x12345678 with WRITE_ALLOC=0 -> D_MEM[0x100] updated, no fill, MissCount+1; a following read of 0x100 misses (8-cycle stall).
REQ-038 rst pulsed during the 4th cycle of a FILL -> Stall=0 and counters 0; the retried read misses again.
REQ-039 MemRead=1 and MemWrite=1 together at 0x002 with DataIn=0x55 -> a write sequence only, D_MEM[2]=0x55.
